// File: rtl/gc_pkg.sv
// Shared constants, state type and successor helper for the 5-bit cyclic Gray-code stages.
// The 22-long virtual sequence runs V = 5..26 and wraps back to 5.
package gc_pkg;

  localparam logic [4:0] VSB_MIN   = 5'd5;
  localparam logic [4:0] VSB_MAX   = 5'd26;
  localparam logic [4:0] F1_OFFSET = 5'd16;
  localparam logic [4:0] F0_OFFSET = 5'd5;
  localparam int         SEQ_LEN   = 22;

  typedef enum logic {
    ACQ  = 1'b0,
    LOCK = 1'b1
  } gc_chk_state_t;

  // Stepping back SEQ_LEN-1 from the top of the range lands on VSB_MIN.
  function automatic logic [4:0] gc_succ(input logic [4:0] v);
    return (v == VSB_MAX) ? (v - 5'(SEQ_LEN - 1)) : (v + 5'd1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder (prefix XOR from the MSB down), any width.
// Zero latency, no state, no flow control.
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o[W-1] = gray_i[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/gray_seq_checker.sv
// Gray sequence checker: recovers B/F from each word, flags range/sequence errors, tracks lock; 1-cycle registered latency.
// No backpressure, one word per cycle; the ERR_CNT counter exists only when GC_CHK_ERRCNT_EN is defined.
module gray_seq_checker
  import gc_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       G,
  input  logic             G_VALID,
  output logic [3:0]       B,
  output logic             F,
  output logic             B_VALID,
  output logic             ERR,
  output logic             LOCKED,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  logic [4:0]    v;
  gc_chk_state_t state_q, state_d;
  logic [4:0]    prev_q, prev_d;
  logic          prev_ok_q, prev_ok_d;
  logic [3:0]    acq_n_q, acq_n_d;
  logic [3:0]    b_q, b_d;
  logic          f_q, f_d;
  logic          b_valid_q, b_valid_d;
  logic          err_q, err_d;
  logic          in_range, in_seq, is_f1;

  gray_to_bin #(.W(5)) u_dec (
    .gray_i (G),
    .bin_o  (v)
  );

  assign in_range = (v >= VSB_MIN) && (v <= VSB_MAX);
  assign in_seq   = (v == gc_succ(prev_q));
  assign is_f1    = (v >= F1_OFFSET);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    acq_n_d   = acq_n_q;
    b_d       = b_q;
    f_d       = f_q;
    b_valid_d = 1'b0;
    err_d     = 1'b0;
    if (G_VALID) begin
      if (!in_range) begin
        err_d     = 1'b1;
        prev_ok_d = 1'b0;
        acq_n_d   = 4'd0;
        state_d   = ACQ;
      end else begin
        b_valid_d = 1'b1;
        f_d       = is_f1;
        // Offsets are 16 and 5; the low nibble alone gives the 0..10 count.
        b_d       = is_f1 ? (v[3:0] - F1_OFFSET[3:0]) : (v[3:0] - F0_OFFSET[3:0]);
        prev_d    = v;
        prev_ok_d = 1'b1;
        if (state_q == ACQ) begin
          if (prev_ok_q && in_seq) begin
            acq_n_d = (acq_n_q == 4'hF) ? acq_n_q : acq_n_q + 4'd1;
          end else begin
            acq_n_d = 4'd1;
          end
          if (acq_n_d >= LOCK_N) begin
            state_d = LOCK;
          end
        end else if (!in_seq) begin
          err_d   = 1'b1;
          state_d = ACQ;
          acq_n_d = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ACQ;
      prev_q    <= 5'd0;
      prev_ok_q <= 1'b0;
      acq_n_q   <= 4'd0;
      b_q       <= 4'd0;
      f_q       <= 1'b0;
      b_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      acq_n_q   <= acq_n_d;
      b_q       <= b_d;
      f_q       <= f_d;
      b_valid_q <= b_valid_d;
      err_q     <= err_d;
    end
  end

  assign B       = b_q;
  assign F       = f_q;
  assign B_VALID = b_valid_q;
  assign ERR     = err_q;
  assign LOCKED  = (state_q == LOCK);

`ifdef GC_CHK_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed plus randomized bench for gray_seq_checker against a rule-level reference model.
module tb_gray_seq_checker;

  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 2;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic             CLK;
  logic             RST;
  logic [4:0]       G;
  logic             G_VALID;
  logic [3:0]       B;
  logic             F;
  logic             B_VALID;
  logic             ERR;
  logic             LOCKED;
  logic [ERR_W-1:0] ERR_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int e_b, e_f, e_bv, e_err, e_locked, e_cnt;
  int m_prev, m_prev_ok, m_run;

  gray_seq_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .G       (G),
    .G_VALID (G_VALID),
    .B       (B),
    .F       (F),
    .B_VALID (B_VALID),
    .ERR     (ERR),
    .LOCKED  (LOCKED),
    .ERR_CNT (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [4:0] to_gray(input int v);
    return 5'(v ^ (v >> 1));
  endfunction

  // Decode by searching for the value whose Gray encoding matches.
  function automatic int gray_dec(input logic [4:0] g);
    for (int v = 0; v < 32; v++) begin
      if (to_gray(v) == g) return v;
    end
    return -1;
  endfunction

  function automatic int succ(input int v);
    return 5 + ((v - 5 + 1) % 22);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_b = 0; e_f = 0; e_bv = 0; e_err = 0; e_locked = 0; e_cnt = 0;
    m_prev = 0; m_prev_ok = 0; m_run = 0;
  endtask

  task automatic model_step(input bit vld, input logic [4:0] g);
    int  v;
    bit  good;
    e_bv  = 0;
    e_err = 0;
    if (vld) begin
      v = gray_dec(g);
      if (v < 5 || v > 26) begin
        e_err = 1; m_prev_ok = 0; m_run = 0; e_locked = 0;
      end else begin
        e_bv = 1;
        e_f  = (v >= 16) ? 1 : 0;
        e_b  = e_f ? v - 16 : v - 5;
        good = (m_prev_ok != 0) && (v == succ(m_prev));
        if (e_locked != 0) begin
          if (!good) begin
            e_err = 1; e_locked = 0; m_run = 1;
          end
        end else begin
          m_run = good ? m_run + 1 : 1;
          if (m_run >= LOCK_CNT) e_locked = 1;
        end
        m_prev = v; m_prev_ok = 1;
      end
`ifdef GC_CHK_ERRCNT_EN
      if (e_err != 0 && e_cnt < CNT_MAX) e_cnt++;
`endif
    end
  endtask

  task automatic cycle(input bit rst, input bit vld, input logic [4:0] g);
    RST = rst; G_VALID = vld; G = g;
    @(posedge CLK);
    #1;
    if (rst) model_reset();
    else     model_step(vld, g);
    chk("B",       int'(B),       e_b);
    chk("F",       int'(F),       e_f);
    chk("B_VALID", int'(B_VALID), e_bv);
    chk("ERR",     int'(ERR),     e_err);
    chk("LOCKED",  int'(LOCKED),  e_locked);
    chk("ERR_CNT", int'(ERR_CNT), e_cnt);
  endtask

  initial begin
    int cur, nv, k;
    bit vld;
    model_reset();
    RST = 1'b1; G_VALID = 1'b0; G = 5'd0;

    // T1: reset then one full lap from V=16
    cycle(1, 0, 5'd0);
    chk("rst_locked", int'(LOCKED), 0);
    chk("rst_b", int'(B), 0);
    for (int i = 0; i < 22; i++) cycle(0, 1, to_gray(5 + ((11 + i) % 22)));
    chk("t1_last_b", int'(B), 10);
    chk("t1_last_f", int'(F), 0);
    chk("t1_locked", int'(LOCKED), 1);

    // T2: another lap covering 26->5 and 15->16 wraps while locked
    for (int i = 0; i < 23; i++) cycle(0, 1, to_gray(5 + ((11 + i) % 22)));
    chk("t2_locked", int'(LOCKED), 1);
    chk("t2_b", int'(B), 0);
    chk("t2_f", int'(F), 1);

    // T3: range error then reacquire
    cycle(0, 1, 5'h02);
    chk("t3_err", int'(ERR), 1);
    chk("t3_bvalid", int'(B_VALID), 0);
    chk("t3_b_held", int'(B), 0);
    cycle(0, 1, 5'h18);
    cycle(0, 1, 5'h19);
    cycle(0, 1, 5'h1B);
    chk("t3_relock", int'(LOCKED), 1);

    // T4: skip 18->20, recover, then a repeated word
    cycle(0, 1, to_gray(20));
    chk("t4_err", int'(ERR), 1);
    chk("t4_b", int'(B), 4);
    chk("t4_f", int'(F), 1);
    chk("t4_locked", int'(LOCKED), 0);
    cycle(0, 1, to_gray(21));
    cycle(0, 1, to_gray(22));
    chk("t4_relock", int'(LOCKED), 1);
    cycle(0, 1, to_gray(22));
    chk("t4_repeat_err", int'(ERR), 1);

    // T5: gapped lap, then reset while locked with a valid word present
    cycle(1, 0, 5'd0);
    for (int i = 0; i < 44; i++) begin
      if (i % 2 == 0) cycle(0, 1, to_gray(5 + ((11 + i / 2) % 22)));
      else            cycle(0, 0, 5'($urandom_range(0, 31)));
    end
    chk("t5_locked", int'(LOCKED), 1);
    cycle(1, 1, to_gray(16));
    chk("t5_rst_locked", int'(LOCKED), 0);
    chk("t5_rst_bvalid", int'(B_VALID), 0);

    // T6: counter saturation
    for (int i = 0; i < 6; i++) cycle(0, 1, to_gray(1 + (i % 4)));
`ifdef GC_CHK_ERRCNT_EN
    chk("t6_cnt_sat", int'(ERR_CNT), CNT_MAX);
`else
    chk("t6_cnt_zero", int'(ERR_CNT), 0);
`endif
    cycle(0, 0, 5'd0);

    // Randomized: mostly legal steps with injected errors, gaps and resets
    cur = 5;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        cycle(1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
        continue;
      end
      vld = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 19);
      if (k < 16)       nv = succ(cur);
      else if (k == 16) nv = $urandom_range(0, 31);
      else if (k == 17) nv = cur;
      else              nv = succ(succ(cur));
      if (vld && nv >= 5 && nv <= 26) cur = nv;
      cycle(0, vld, vld ? to_gray(nv) : 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
